keystream_xor: RTL and testbench
================================

KEYSTREAM_XOR -- requirements
Module: keystream_xor

Interface
REQ-001 SHALL have parameter LEN_W, default 16, width of the message byte-length input and the internal byte counter.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port start  input  1  one-cycle request to begin a message; sampled only in IDLE.
REQ-005 SHALL have port len  input  LEN_W  message length in bytes; captured on an accepted start.
REQ-006 SHALL have port ks_bit  input  1  serial keystream bit from the keystream generator.
REQ-007 SHALL have port ks_valid  input  1  ks_bit is valid.
REQ-008 SHALL have port ks_ready  output  1  block accepts ks_bit this cycle.
REQ-009 SHALL have port pt_data  input  8  plaintext (or ciphertext) byte.
REQ-010 SHALL have port pt_valid  input  1  pt_data is valid.
REQ-011 SHALL have port pt_ready  output  1  pt_data consumed this cycle.
REQ-012 SHALL have port ct_data  output  8  result byte (pt_data XOR keystream byte).
REQ-013 SHALL have port ct_valid  output  1  ct_data is valid.
REQ-014 SHALL have port ct_ready  input  1  downstream accepts ct_data.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle pulse at message completion.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, FLUSH, FIN.
REQ-018 SHALL leave IDLE on start=1: to FIN if len==0, else to RUN with bytes_left=len, bit_cnt=0.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL drive ks_ready=1 only in RUN while bit_cnt<8; a bit transfers when ks_valid&&ks_ready.
REQ-021 SHALL place the first accepted bit of each byte in ks_byte[0] and the eighth in ks_byte[7] (LSB-first).
REQ-022 SHALL perform a combine in RUN when bit_cnt==8 && pt_valid && (!ct_valid || ct_ready), asserting pt_ready combinationally only in that cycle.
REQ-023 SHALL on combine load ct_data=pt_data^ks_byte, set ct_valid=1, reset bit_cnt=0, decrement bytes_left.
REQ-024 SHALL go RUN->FLUSH on the combine where bytes_left==1.
REQ-025 SHALL hold ct_data and ct_valid stable until ct_valid&&ct_ready; ct_valid clears on that cycle unless a new combine reloads it the same cycle.
REQ-026 SHALL go FLUSH->FIN when ct_valid==0 or ct_ready==1.
REQ-027 SHALL in FIN assert done for exactly one cycle and return to IDLE next cycle.
REQ-028 SHALL give a minimum of 9 cycles per byte from first ks bit to ct_valid (8 bit cycles + 1 combine cycle) under no stalls.
REQ-029 SHALL never accept a ninth ks bit before a combine, and never assert pt_ready outside RUN.
REQ-030 SHALL wrap no counter: bytes_left decrements only while nonzero; bit_cnt saturates at 8.

Reset
REQ-031 SHALL on reset=1, immediately and regardless of clk, force state=IDLE, bit_cnt=0, bytes_left=0, ks_byte=0, ct_data=0, ct_valid=0, done=0.
REQ-032 SHALL abandon any in-flight message on reset mid-operation; no done pulse is generated for it.
REQ-033 SHALL hold ks_ready=0, pt_ready=0, busy=0 while reset is high.

Structure
REQ-034 SHALL place state encoding (IDLE/RUN/FLUSH/FIN) and the byte width constant 8 in the shared cipher package.
REQ-035 SHALL implement the serial-to-byte gatherer as sub-module ks_deserializer (ks_bit in, 8-bit byte + full flag out, clear input); the rest stays in keystream_xor.

Verification
REQ-036 SHALL cover: len=1, ks bits 1,0,1,0,0,0,0,0, pt=0xA0 -> ct_data=0xA5, one ct_valid beat, done pulse once.
REQ-037 SHALL cover: start with len=0 -> busy one cycle, done pulse, pt_ready and ks_ready never high.
REQ-038 SHALL cover: len=2, ct_ready low 10 cycles after first ct -> ct_data stable, ks_ready drops after 8 bits, pt_ready low until ct_ready rises.
REQ-039 SHALL cover: reset asserted after 4 ks bits of byte 2 of len=3 -> all outputs at reset values, no done, next start len=1 works.
REQ-040 SHALL cover: start pulsed during RUN with different len -> ignored, original len bytes produced.
REQ-041 SHALL cover: len=3 with ks_valid and pt_valid randomly gapped -> ct bytes equal reference XOR model in order.

Source files
------------

// File: rtl/keystream_xor_pkg.sv
// rtl/keystream_xor_pkg.sv - shared cipher constants and FSM state encoding
package keystream_xor_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    FIN   = 2'd3
  } state_t;

endpackage

// File: rtl/ks_deserializer.sv
// rtl/ks_deserializer.sv - gathers serial keystream bits LSB-first into a byte
module ks_deserializer
  import keystream_xor_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              shift,
  input  logic              bit_in,
  output logic [BYTE_W-1:0] data,
  output logic              full
);

  logic [CNT_W-1:0] cnt;

  // Count saturates at BYTE_W so a ninth bit can never be taken before a clear.
  assign full = (cnt == CNT_W'(BYTE_W));

  // Shift register: the first accepted bit lands in data[0]; clear restarts the byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      data <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (shift && !full) begin
      data[cnt[2:0]] <= bit_in;
      cnt            <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/keystream_xor.sv
// rtl/keystream_xor.sv - XORs a byte stream with a serially delivered keystream
module keystream_xor
  import keystream_xor_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              ks_bit,
  input  logic              ks_valid,
  output logic              ks_ready,
  input  logic [BYTE_W-1:0] pt_data,
  input  logic              pt_valid,
  output logic              pt_ready,
  output logic [BYTE_W-1:0] ct_data,
  output logic              ct_valid,
  input  logic              ct_ready,
  output logic              busy,
  output logic              done
);

  state_t            state;
  logic [LEN_W-1:0]  bytes_left;
  logic [BYTE_W-1:0] ks_byte;
  logic              ks_full;
  logic              ks_fire;
  logic              combine;
  logic              ct_take;
  logic              des_clear;

  // Keystream is only pulled while a message runs and the current byte is incomplete.
  assign ks_ready  = (state == RUN) && !ks_full;
  assign ks_fire   = ks_valid && ks_ready;

  // A combine needs a full keystream byte, a plaintext byte and room in the output slot.
  assign combine   = (state == RUN) && ks_full && pt_valid && (!ct_valid || ct_ready);
  assign pt_ready  = combine;
  assign ct_take   = ct_valid && ct_ready;
  assign busy      = (state != IDLE);

  // Restart byte gathering on every new message and after each combine.
  assign des_clear = combine || ((state == IDLE) && start);

  ks_deserializer u_des (
    .clk    (clk),
    .reset  (reset),
    .clear  (des_clear),
    .shift  (ks_fire),
    .bit_in (ks_bit),
    .data   (ks_byte),
    .full   (ks_full)
  );

  // Message sequencing: length capture, per-byte countdown, drain and completion pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      bytes_left <= '0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len == '0) begin
              state <= FIN;
              done  <= 1'b1;
            end else begin
              state      <= RUN;
              bytes_left <= len;
            end
          end
        end
        RUN: begin
          if (combine) begin
            if (bytes_left != '0) begin
              bytes_left <= bytes_left - LEN_W'(1);
            end
            if (bytes_left <= LEN_W'(1)) begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          if (!ct_valid || ct_ready) begin
            state <= FIN;
            done  <= 1'b1;
          end
        end
        FIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Output slot: loaded on combine, held until the downstream takes it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ct_data  <= '0;
      ct_valid <= 1'b0;
    end else if (combine) begin
      ct_data  <= pt_data ^ ks_byte;
      ct_valid <= 1'b1;
    end else if (ct_take) begin
      ct_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_keystream_xor.sv
// tb/tb_keystream_xor.sv - randomized self-checking bench with a reference XOR model
module tb_keystream_xor;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] len;
  logic        ks_bit;
  logic        ks_valid;
  logic        ks_ready;
  logic [7:0]  pt_data;
  logic        pt_valid;
  logic        pt_ready;
  logic [7:0]  ct_data;
  logic        ct_valid;
  logic        ct_ready;
  logic        busy;
  logic        done;

  keystream_xor #(.LEN_W(16)) dut (
    .clk      (clk),
    .reset    (rst),
    .start    (start),
    .len      (len),
    .ks_bit   (ks_bit),
    .ks_valid (ks_valid),
    .ks_ready (ks_ready),
    .pt_data  (pt_data),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .ct_data  (ct_data),
    .ct_valid (ct_valid),
    .ct_ready (ct_ready),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model state: every accepted keystream bit and the expected output bytes.
  bit         model_bits[$];
  logic [7:0] exp_q[$];
  bit         force_bits[$];
  bit         use_force_pt;
  logic [7:0] force_pt;
  logic [7:0] last_ct;
  int n_bits, n_pt, n_ct, n_done, n_busy;
  bit saw_ks_ready, saw_pt_ready;
  int ks_pct, pt_pct, cr_pct;

  task automatic clear_model();
    model_bits.delete();
    exp_q.delete();
    force_bits.delete();
    use_force_pt = 1'b0;
    n_bits = 0; n_pt = 0; n_ct = 0; n_done = 0; n_busy = 0;
    saw_ks_ready = 1'b0; saw_pt_ready = 1'b0;
    ks_pct = 100; pt_pct = 100; cr_pct = 100;
  endtask

  // One clock: drive inputs at the falling edge, observe handshakes just after.
  task automatic step(input logic st, input logic [15:0] l);
    logic [7:0] kb;
    @(negedge clk);
    start    = st;
    len      = l;
    ks_valid = ($urandom_range(99) < ks_pct);
    ks_bit   = (n_bits < force_bits.size()) ? force_bits[n_bits] : 1'($urandom_range(1));
    pt_valid = ($urandom_range(99) < pt_pct);
    pt_data  = use_force_pt ? force_pt : 8'($urandom);
    ct_ready = ($urandom_range(99) < cr_pct);
    #1;
    if (busy) n_busy++;
    if (ks_ready) saw_ks_ready = 1'b1;
    if (pt_ready) saw_pt_ready = 1'b1;
    if (ct_valid && ct_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL ct_unexpected: got %02h, required no output", ct_data);
      end else begin
        kb = exp_q.pop_front();
        if (ct_data !== kb) begin
          fails++;
          $display("FAIL ct_data[%0d]: got %02h, required %02h", n_ct, ct_data, kb);
        end
      end
      last_ct = ct_data;
      n_ct++;
    end
    if (ks_valid && ks_ready) begin
      model_bits.push_back(ks_bit);
      n_bits++;
      tests++;
      if (n_bits > 8 * n_pt + 8) begin
        fails++;
        $display("FAIL ks_overrun: got %0d bits, required at most %0d", n_bits, 8 * n_pt + 8);
      end
    end
    if (pt_valid && pt_ready) begin
      tests++;
      if (n_bits != 8 * n_pt + 8) begin
        fails++;
        $display("FAIL pt_early: got %0d bits, required %0d", n_bits, 8 * n_pt + 8);
      end else begin
        for (int i = 0; i < 8; i++) kb[i] = model_bits[8 * n_pt + i];
        exp_q.push_back(pt_data ^ kb);
      end
      n_pt++;
    end
    if (done) n_done++;
  endtask

  task automatic run_until_done(input int max_cycles, input string name);
    int c;
    c = 0;
    while (n_done == 0 && c < max_cycles) begin
      step(1'b0, 16'd0);
      c++;
    end
    if (n_done == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got no done, required done within %0d cycles", name, max_cycles);
    end
    repeat (3) step(1'b0, 16'd0);
  endtask

  task automatic check_int(input string name, input int got, input int req);
    tests++;
    if (got != req) begin
      fails++;
      $display("FAIL %s: got %0d, required %0d", name, got, req);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({ks_ready, pt_ready, busy, ct_valid, done, ct_data} !== 13'd0) begin
      fails++;
      $display("FAIL reset_outputs: got %013b, required 0",
               {ks_ready, pt_ready, busy, ct_valid, done, ct_data});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_single_byte();
    clear_model();
    force_bits = '{1, 0, 1, 0, 0, 0, 0, 0};
    use_force_pt = 1'b1;
    force_pt = 8'hA0;
    step(1'b1, 16'd1);
    run_until_done(100, "single");
    check_int("single_ct_count", n_ct, 1);
    tests++;
    if (last_ct !== 8'hA5) begin
      fails++;
      $display("FAIL single_ct_value: got %02h, required a5", last_ct);
    end
    check_int("single_done_count", n_done, 1);
  endtask

  task automatic test_zero_len();
    clear_model();
    step(1'b1, 16'd0);
    repeat (5) step(1'b0, 16'd0);
    check_int("zero_busy_cycles", n_busy, 1);
    check_int("zero_done_count", n_done, 1);
    check_int("zero_ready_seen", int'(saw_ks_ready) + int'(saw_pt_ready), 0);
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int c;
    bit stable;
    clear_model();
    cr_pct = 0;
    step(1'b1, 16'd2);
    c = 0;
    while (!ct_valid && c < 50) begin
      step(1'b0, 16'd0);
      c++;
    end
    check_int("bp_first_ct_seen", int'(ct_valid), 1);
    held = ct_data;
    stable = 1'b1;
    saw_pt_ready = 1'b0;
    repeat (10) begin
      step(1'b0, 16'd0);
      if (ct_data !== held || ct_valid !== 1'b1) stable = 1'b0;
    end
    check_int("bp_ct_stable", int'(stable), 1);
    check_int("bp_bits_gathered", n_bits, 16);
    check_int("bp_ks_ready_low", int'(ks_ready), 0);
    check_int("bp_pt_ready_low", int'(saw_pt_ready), 0);
    cr_pct = 100;
    run_until_done(100, "bp");
    check_int("bp_ct_count", n_ct, 2);
    check_int("bp_done_count", n_done, 1);
  endtask

  task automatic test_reset_mid();
    int c;
    clear_model();
    step(1'b1, 16'd3);
    c = 0;
    while (n_bits < 12 && c < 100) begin
      step(1'b0, 16'd0);
      c++;
    end
    check_int("mid_bits_before_reset", n_bits, 12);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++;
    if ({ks_ready, pt_ready, busy, ct_valid, done, ct_data} !== 13'd0) begin
      fails++;
      $display("FAIL mid_reset_outputs: got %013b, required 0",
               {ks_ready, pt_ready, busy, ct_valid, done, ct_data});
    end
    clear_model();
    repeat (3) step(1'b0, 16'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) step(1'b0, 16'd0);
    check_int("mid_no_done", n_done, 0);
    clear_model();
    step(1'b1, 16'd1);
    run_until_done(100, "mid_after");
    check_int("mid_after_ct_count", n_ct, 1);
    check_int("mid_after_done", n_done, 1);
  endtask

  task automatic test_ignore_start();
    clear_model();
    step(1'b1, 16'd2);
    repeat (4) step(1'b0, 16'd0);
    step(1'b1, 16'd5);
    step(1'b1, 16'd1);
    run_until_done(200, "ign");
    check_int("ign_ct_count", n_ct, 2);
    check_int("ign_pt_count", n_pt, 2);
    check_int("ign_done_count", n_done, 1);
  endtask

  task automatic test_random_gaps();
    for (int it = 0; it < 6; it++) begin
      clear_model();
      ks_pct = $urandom_range(90, 30);
      pt_pct = $urandom_range(90, 30);
      cr_pct = $urandom_range(90, 30);
      step(1'b1, 16'd3);
      run_until_done(600, "rand");
      check_int("rand_ct_count", n_ct, 3);
      check_int("rand_done_count", n_done, 1);
      check_int("rand_leftover", exp_q.size(), 0);
    end
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    len      = '0;
    ks_bit   = 1'b0;
    ks_valid = 1'b0;
    pt_data  = '0;
    pt_valid = 1'b0;
    ct_ready = 1'b0;
    clear_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_single_byte();
    test_zero_len();
    test_backpressure();
    test_reset_mid();
    test_ignore_start();
    test_random_gaps();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
